// File: rtl/arith_sched_if.sv
// Requester and arithmetic_ip signal bundle for arith_sched.
// master: requesters plus the arithmetic_ip stub; slave: the scheduler itself.
interface arith_sched_if;
    logic [3:0] req;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] req_m;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_m;
    logic [2:0] alu_s;
    logic       alu_cout;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [2:0] rsp_s;
    logic       rsp_cout;

    modport master (
        output req, req_a, req_b, req_m, alu_s, alu_cout,
        input  gnt, busy, alu_a, alu_b, alu_m, rsp_valid, rsp_id, rsp_s, rsp_cout
    );

    modport slave (
        input  req, req_a, req_b, req_m, alu_s, alu_cout,
        output gnt, busy, alu_a, alu_b, alu_m, rsp_valid, rsp_id, rsp_s, rsp_cout
    );
endinterface

// File: rtl/arith_sched.sv
// Round-robin scheduler sharing one arithmetic_ip among four requesters.
// Optional macro ARITH_SCHED_CNT_EN adds an 8-bit completed-operation counter output op_cnt.
module arith_sched #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    arith_sched_if.slave      bus
`ifdef ARITH_SCHED_CNT_EN
    ,
    output logic [7:0]        op_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] alu_a_q, alu_a_d;
    logic [1:0] alu_b_q, alu_b_d;
    logic [1:0] alu_m_q, alu_m_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [1:0] rsp_id_q, rsp_id_d;
    logic [2:0] rsp_s_q, rsp_s_d;
    logic       rsp_cout_q, rsp_cout_d;
`ifdef ARITH_SCHED_CNT_EN
    logic [7:0] op_cnt_q, op_cnt_d;
`endif

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = '0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_m_d     = alu_m_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef ARITH_SCHED_CNT_EN
        op_cnt_d    = op_cnt_q + {7'd0, rsp_valid_q};
`endif

        // First requesting index scanning upward from the one after the last winner.
        win   = last_q + 2'd1;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = last_q + 2'(i + 1);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    gnt_d      = 4'b0001 << win;
                    alu_a_d    = bus.req_a[{win, 1'b0} +: 2];
                    alu_b_d    = bus.req_b[{win, 1'b0} +: 2];
                    alu_m_d    = bus.req_m[{win, 1'b0} +: 2];
                    last_d     = win;
                    cnt_d      = '0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    rsp_s_d     = bus.alu_s;
                    rsp_cout_d  = bus.alu_cout;
                    rsp_id_d    = last_q;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 2'd3;
            gnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_m_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
`ifdef ARITH_SCHED_CNT_EN
            op_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_m_q     <= alu_m_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
`ifdef ARITH_SCHED_CNT_EN
            op_cnt_q    <= op_cnt_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == EXEC);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_m     = alu_m_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.rsp_cout  = rsp_cout_q;
`ifdef ARITH_SCHED_CNT_EN
    assign op_cnt        = op_cnt_q;
`endif

endmodule

// File: tb/tb_arith_sched.sv
// Randomized and directed bench for arith_sched with ALU_LAT=1 and ALU_LAT=3 instances.
// Also checks op_cnt when built with ARITH_SCHED_CNT_EN.
module tb_arith_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  req_a, req_b, req_m;
    logic        stub_fixed;
    logic        sel3;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // arithmetic_ip stub: returns {cout, s}; time-varying term exposes capture-cycle errors
    function automatic logic [3:0] stub(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] m, input logic [1:0] c,
                                        input logic fixed);
        logic [2:0] s;
        logic       co;
        if (fixed) return 4'b0100;
        case (m)
            2'd0:    s = {1'b0, a} + {1'b0, b};
            2'd1:    s = {1'b0, a} - {1'b0, b};
            2'd2:    s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        s  = s ^ {c[0], 2'b00};
        co = a[0] ^ b[1] ^ m[1] ^ c[1];
        return {co, s};
    endfunction

    arith_sched_if bus1();
    arith_sched_if bus3();

    assign bus1.req = req;   assign bus3.req = req;
    assign bus1.req_a = req_a; assign bus3.req_a = req_a;
    assign bus1.req_b = req_b; assign bus3.req_b = req_b;
    assign bus1.req_m = req_m; assign bus3.req_m = req_m;
    assign {bus1.alu_cout, bus1.alu_s} = stub(bus1.alu_a, bus1.alu_b, bus1.alu_m, cyc[1:0], stub_fixed);
    assign {bus3.alu_cout, bus3.alu_s} = stub(bus3.alu_a, bus3.alu_b, bus3.alu_m, cyc[1:0], stub_fixed);

`ifdef ARITH_SCHED_CNT_EN
    logic [7:0] op_cnt1, op_cnt3, o_op;
    assign o_op = sel3 ? op_cnt3 : op_cnt1;
`endif

    arith_sched #(.ALU_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef ARITH_SCHED_CNT_EN
        , .op_cnt(op_cnt1)
`endif
    );

    arith_sched #(.ALU_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
`ifdef ARITH_SCHED_CNT_EN
        , .op_cnt(op_cnt3)
`endif
    );

    logic [3:0] o_gnt;
    logic       o_busy, o_rv;
    logic [5:0] o_ops;
    logic [5:0] o_rsp;
    assign o_gnt  = sel3 ? bus3.gnt : bus1.gnt;
    assign o_busy = sel3 ? bus3.busy : bus1.busy;
    assign o_rv   = sel3 ? bus3.rsp_valid : bus1.rsp_valid;
    assign o_ops  = sel3 ? {bus3.alu_a, bus3.alu_b, bus3.alu_m} : {bus1.alu_a, bus1.alu_b, bus1.alu_m};
    assign o_rsp  = sel3 ? {bus3.rsp_id, bus3.rsp_cout, bus3.rsp_s} : {bus1.rsp_id, bus1.rsp_cout, bus1.rsp_s};

    // Reference model: countdown of remaining execute cycles plus a rotation pointer
    int         lat = 1;
    int         rem = 0;
    int         ptr = 3;
    int         own = 0;
    int unsigned n_rsp = 0;
    logic [3:0] e_gnt = '0;
    logic       e_busy = 1'b0, e_rv = 1'b0, e_cout = 1'b0;
    logic [1:0] e_a = '0, e_b = '0, e_m = '0, e_id = '0;
    logic [2:0] e_s = '0;
    logic [7:0] e_op = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic predict();
        int  w;
        bit  f;
        if (!rst_n) begin
            rem = 0; ptr = 3; own = 0;
            e_gnt = '0; e_rv = 1'b0; e_id = '0; e_s = '0; e_cout = 1'b0;
            e_a = '0; e_b = '0; e_m = '0; e_op = '0;
        end else begin
            e_op  = e_op + (e_rv ? 8'd1 : 8'd0);
            e_gnt = '0;
            e_rv  = 1'b0;
            if (rem == 0) begin
                if (req != '0) begin
                    f = 0; w = 0;
                    for (int k = 1; k <= 4; k++)
                        if (!f && req[(ptr + k) % 4]) begin w = (ptr + k) % 4; f = 1; end
                    e_gnt = 4'(1 << w);
                    e_a = req_a[2*w +: 2]; e_b = req_b[2*w +: 2]; e_m = req_m[2*w +: 2];
                    own = w; ptr = w; rem = lat;
                end
            end else begin
                rem--;
                if (rem == 0) begin
                    e_rv = 1'b1;
                    e_id = 2'(own);
                    {e_cout, e_s} = stub(e_a, e_b, e_m, cyc[1:0], stub_fixed);
                    n_rsp++;
                end
            end
        end
        e_busy = (rem != 0);
    endtask

    // Inputs are already set for this cycle; advance one edge and compare at the falling edge.
    task automatic tick();
        predict();
        @(negedge clk);
        check("gnt", 32'(o_gnt), 32'(e_gnt));
        check("busy", 32'(o_busy), 32'(e_busy));
        check("rsp_valid", 32'(o_rv), 32'(e_rv));
        check("alu_ops", 32'(o_ops), 32'({e_a, e_b, e_m}));
        check("rsp", 32'(o_rsp), 32'({e_id, e_cout, e_s}));
`ifdef ARITH_SCHED_CNT_EN
        check("op_cnt", 32'(o_op), 32'(e_op));
`endif
    endtask

    task automatic do_reset(input logic use3);
        sel3 = use3;
        lat  = use3 ? 3 : 1;
        req  = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_m = 8'($urandom);
    endtask

    task automatic run_random(input logic use3, input int n);
        logic [3:0] pending;
        do_reset(use3);
        pending = '0;
        for (int c = 0; c < n; c++) begin
            pending = pending & ~o_gnt;
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) pending[i] = 1'b1;
                else if (pending[i] && $urandom_range(0, 15) == 0) pending[i] = 1'b0;
            end
            req = pending;
            rand_ops();
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] g_val [5];
        int unsigned g_cyc [5];
        int ng;
        logic [5:0] saved;

        stub_fixed = 1'b0;
        sel3 = 1'b0;
        req = '0; req_a = '0; req_b = '0; req_m = '0;
        rst_n = 1'b0;

        // Reset state and single grant with a fixed stub result
        do_reset(1'b0);
        check("reset_zero", 32'({o_gnt, o_busy, o_rv, o_ops, o_rsp}), 32'd0);
        stub_fixed = 1'b1;
        req = 4'b0010; req_a = 8'b0000_1100; req_b = 8'b0000_0100; req_m = 8'h00;
        tick();
        check("t032_gnt", 32'(o_gnt), 32'(4'b0010));
        check("t032_ops", 32'(o_ops), 32'(6'b11_01_00));
        req = '0;
        tick();
        check("t032_rv", 32'(o_rv), 32'd1);
        check("t032_rsp", 32'(o_rsp), 32'(6'b01_0_100));
        stub_fixed = 1'b0;
        tick();

        // All four requesting from reset: rotation order and spacing
        do_reset(1'b0);
        req = 4'hF;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            rand_ops();
            tick();
            if (o_gnt != '0 && ng < 5) begin g_val[ng] = o_gnt; g_cyc[ng] = cyc; ng++; end
        end
        check("t033_count", 32'(ng), 32'd5);
        for (int k = 0; k < ng; k++) begin
            check("t033_order", 32'(g_val[k]), 32'(4'b0001 << (k % 4)));
            if (k > 0) check("t033_gap", g_cyc[k] - g_cyc[k-1], 32'd2);
        end
        req = '0;
        tick(); tick();

        // ALU_LAT=3: busy window, response timing, operands frozen after grant
        do_reset(1'b1);
        req = 4'b0001; rand_ops();
        tick();
        check("t034_gnt", 32'(o_gnt), 32'(4'b0001));
        saved = o_ops;
        req = '0;
        for (int k = 0; k < 3; k++) begin
            check("t034_busy", 32'(o_busy), 32'd1);
            check("t034_no_rv", 32'(o_rv), 32'd0);
            check("t034_ops_hold", 32'(o_ops), 32'(saved));
            rand_ops();
            tick();
        end
        check("t034_rv", 32'(o_rv), 32'd1);
        check("t034_idle", 32'(o_busy), 32'd0);
        tick();

        // Reset mid-operation: no response, outputs cleared, requester 0 first again
        do_reset(1'b1);
        req = 4'b0100; rand_ops();
        tick();
        check("t035_gnt", 32'(o_gnt), 32'(4'b0100));
        rst_n = 1'b0; req = '0;
        tick();
        check("t035_zero", 32'({o_gnt, o_busy, o_rv, o_ops, o_rsp}), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t035_no_rv", 32'(o_rv), 32'd0);
        end
        req = 4'hF;
        tick();
        check("t035_regrant", 32'(o_gnt), 32'(4'b0001));
        req = '0;
        for (int k = 0; k < 4; k++) tick();

`ifdef ARITH_SCHED_CNT_EN
        // 257 completions wrap the counter to 1
        do_reset(1'b0);
        n_rsp = 0;
        req = 4'b0001;
        for (int c = 0; c < 1200 && n_rsp < 257; c++) begin
            rand_ops();
            tick();
        end
        check("t036_ops_done", n_rsp, 32'd257);
        req = '0;
        tick();
        check("t036_op_cnt", 32'(o_op), 32'd1);
`endif

        run_random(1'b0, 800);
        run_random(1'b1, 800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
